// File: rtl/sign_mag_sub_ser.sv
// Bit-serial sign-magnitude subtractor: Diff = A - B, computed as A + (-B).
// N-bit operands: sign at MSB, N-1 magnitude bits processed LSB first.
// Flow: IDLE (accept) -> CMP (pick add/sub mode and result sign) ->
// SER (N-1 bit cycles plus one commit cycle) -> DONE (hold until out_ready).
// Handshake: an operand transfer happens on a rising edge where in_valid and
// in_ready are both 1; a result transfer happens on a rising edge where
// out_valid and out_ready are both 1. Each side holds its data until then.
// Optional build macro SIGN_MAG_SUB_SAT_EN: saturate the magnitude on overflow
// instead of wrapping it.
module sign_mag_sub_ser #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         ovf
);

  localparam int M  = N - 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(M);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_SER  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;      // B with its sign already inverted
  logic          add_q, add_d;
  logic          sign_q, sign_d;
  logic [M-1:0]  x_q, x_d;      // larger (or first) magnitude, shifted right
  logic [M-1:0]  y_q, y_d;      // smaller (or second) magnitude, shifted right
  logic [M-1:0]  res_q, res_d;  // result bits shifted in at the MSB
  logic          c_q, c_d;      // carry in add mode, borrow in subtract mode
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          ovf_q, ovf_d;

  logic [M-1:0]  ma, mb, mag_fin;
  logic          sa, sb, bit_r, c_nxt, ovf_fin;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Diff      = diff_q;
  assign ovf       = ovf_q;

  // Effective signs with -0 folded onto +0.
  assign ma = a_q[M-1:0];
  assign mb = b_q[M-1:0];
  assign sa = a_q[N-1] & (|ma);
  assign sb = b_q[N-1] & (|mb);

  // One full-adder / full-subtractor slice on the current LSBs.
  always_comb begin
    bit_r = x_q[0] ^ y_q[0] ^ c_q;
    if (add_q) c_nxt = (x_q[0] & y_q[0]) | (x_q[0] & c_q) | (y_q[0] & c_q);
    else       c_nxt = (~x_q[0] & y_q[0]) | (~x_q[0] & c_q) | (y_q[0] & c_q);
  end

  // Overflow and final magnitude, applied when the result is committed.
  always_comb begin
    ovf_fin = add_q & c_q;
`ifdef SIGN_MAG_SUB_SAT_EN
    mag_fin = ovf_fin ? {M{1'b1}} : res_q;
`else
    mag_fin = res_q;
`endif
  end

  // Next-state logic for the controller and the serial datapath.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    add_d   = add_q;
    sign_d  = sign_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = {~B[N-1], B[M-1:0]};
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        add_d = (sa == sb);
        c_d   = 1'b0;
        cnt_d = '0;
        res_d = '0;
        if (sa == sb || ma >= mb) begin
          x_d    = ma;
          y_d    = mb;
          sign_d = sa;
        end else begin
          x_d    = mb;
          y_d    = ma;
          sign_d = sb;
        end
        state_d = S_SER;
      end
      S_SER: begin
        if (cnt_q != LAST) begin
          res_d        = res_q >> 1;
          res_d[M-1]   = bit_r;
          x_d          = x_q >> 1;
          y_d          = y_q >> 1;
          c_d          = c_nxt;
          cnt_d        = cnt_q + 1'b1;
        end else begin
          ovf_d   = ovf_fin;
          diff_d  = {sign_q & (|mag_fin), mag_fin};
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      add_q   <= 1'b0;
      sign_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      add_q   <= add_d;
      sign_q  <= sign_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sign_mag_sub_ser.sv
// Testbench for sign_mag_sub_ser (N=5): directed spec vectors, stall, reset
// abort, randomized single ops and a randomized streaming run with an
// expected-result queue. Expected values come from signed integer arithmetic.
module tb_sign_mag_sub_ser;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] Diff;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N:0] exp_q[$];

  sign_mag_sub_ser #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .ovf(ovf)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: true signed difference, then ovf/wrap/saturate and +0 rule.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int ma, mb, va, vb, d, mag, maxm;
    logic o, s;
    logic [N-2:0] m;
    ma   = int'(a[N-2:0]);
    mb   = int'(b[N-2:0]);
    va   = a[N-1] ? -ma : ma;
    vb   = b[N-1] ? -mb : mb;
    d    = va - vb;
    mag  = (d < 0) ? -d : d;
    maxm = (1 << (N - 1)) - 1;
    o    = (mag > maxm);
    if (o) begin
`ifdef SIGN_MAG_SUB_SAT_EN
      mag = maxm;
`else
      mag = mag % (maxm + 1);
`endif
    end
    m = mag[N-2:0];
    s = (d < 0) && (mag != 0);
    return {o, s, m};
  endfunction

  // Driver: one full transaction; reports result, latency and stall violations.
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                          output logic [N-1:0] d, output logic o, output int lat,
                          output int hold_bad);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = N'($urandom); B = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    d = Diff; o = ovf; hold_bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (Diff !== d || ovf !== o || in_ready !== 1'b0 || out_valid !== 1'b1) hold_bad++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Diff !== '0 || ovf !== 1'b0)
      $display("FAIL reset: in_ready=%b out_valid=%b Diff=%b ovf=%b, want 1 0 00000 0",
               in_ready, out_valid, Diff, ovf);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [N-1:0] va[5];
    logic [N-1:0] vb[5];
    logic [N-1:0] d;
    logic o;
    logic [N:0] e;
    int lat, hb;
    va = '{5'b00011, 5'b01111, 5'b10011, 5'b10000, 5'b10010};
    vb = '{5'b00101, 5'b11111, 5'b10011, 5'b00000, 5'b00011};
    for (int i = 0; i < 5; i++) begin
      drive_op(va[i], vb[i], 0, d, o, lat, hb);
      e = model(va[i], vb[i]);
      n_checks++;
      if ({o, d} !== e)
        $display("FAIL directed[%0d]: A=%b B=%b got ovf=%b Diff=%b, want ovf=%b Diff=%b",
                 i, va[i], vb[i], o, d, e[N], e[N-1:0]);
      else n_pass++;
      n_checks++;
      if (lat !== N + 1)
        $display("FAIL latency[%0d]: got %0d edges, want %0d", i, lat, N + 1);
      else n_pass++;
    end
    // Literal check of the first vector independent of the model.
    drive_op(5'b00011, 5'b00101, 0, d, o, lat, hb);
    n_checks++;
    if (d !== 5'b10010 || o !== 1'b0)
      $display("FAIL literal_3_minus_5: got %b/%b, want 10010/0", d, o);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [N-1:0] d;
    logic o;
    logic [N:0] e;
    int lat, hb;
    drive_op(5'b10010, 5'b00011, 10, d, o, lat, hb);
    e = model(5'b10010, 5'b00011);
    n_checks++;
    if ({o, d} !== e || d !== 5'b10101)
      $display("FAIL stall_result: got ovf=%b Diff=%b, want ovf=%b Diff=%b", o, d, e[N], e[N-1:0]);
    else n_pass++;
    n_checks++;
    if (hb !== 0) $display("FAIL stall_hold: %0d unstable cycles, want 0", hb);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [N-1:0] d;
    logic o;
    int lat, hb, seen;
    A = 5'b00111; B = 5'b00010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL abort_immediate: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_no_result: out_valid high %0d cycles, want 0", seen);
    else n_pass++;
    drive_op(5'b00001, 5'b00001, 0, d, o, lat, hb);
    n_checks++;
    if (d !== 5'b00000 || o !== 1'b0 || lat !== N + 1)
      $display("FAIL after_abort: Diff=%b ovf=%b lat=%0d, want 00000 0 %0d", d, o, lat, N + 1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, d;
    logic o;
    logic [N:0] e;
    int lat, hb;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom_range(0, (1 << N) - 1));
      b = N'($urandom_range(0, (1 << N) - 1));
      drive_op(a, b, $urandom_range(0, 3), d, o, lat, hb);
      e = model(a, b);
      n_checks++;
      if ({o, d} !== e || lat !== N + 1 || hb !== 0)
        $display("FAIL random[%0d]: A=%b B=%b got ovf=%b Diff=%b lat=%0d hold=%0d, want ovf=%b Diff=%b lat=%0d",
                 i, a, b, o, d, lat, hb, e[N], e[N-1:0], N + 1);
      else n_pass++;
    end
  endtask

  // Streaming: in_valid/out_ready toggle randomly; busy-time inputs are noise.
  task automatic test_back_to_back();
    int issued, got, cyc;
    logic [N:0] e;
    issued = 0; got = 0; cyc = 0;
    exp_q.delete();
    while (got < 20 && cyc < 3000) begin
      in_valid  = (issued < 20) && ($urandom_range(0, 3) != 0);
      A         = N'($urandom);
      B         = N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B));
        issued++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_unexpected: got ovf=%b Diff=%b with empty queue", ovf, Diff);
        end else begin
          e = exp_q.pop_front();
          if ({ovf, Diff} !== e)
            $display("FAIL b2b[%0d]: got ovf=%b Diff=%b, want ovf=%b Diff=%b",
                     got, ovf, Diff, e[N], e[N-1:0]);
          else n_pass++;
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (got !== 20 || exp_q.size() != 0)
      $display("FAIL b2b_count: got %0d results, %0d pending, want 20 and 0", got, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
